// File: rtl/data_sync_na_src_pacer_if.sv
// Upstream valid/ready stream plus the send strobe and data word driven
// toward the no-acknowledge synchronizer.
interface data_sync_na_src_pacer_if #(
  parameter int width = 8
);
  logic             in_valid;
  logic [width-1:0] in_data;
  logic             in_ready;
  logic             send_s;
  logic [width-1:0] data_s;

  modport master (
    output in_valid, in_data,
    input  in_ready, send_s, data_s
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, send_s, data_s
  );
endinterface

// File: rtl/data_sync_na_src_pacer.sv
// Source-side pacer for a no-ack data synchronizer: buffers upstream words in a
// small FIFO and issues them as single-cycle send_s pulses at least min_gap apart.
module data_sync_na_src_pacer #(
  parameter int width   = 8,
  parameter int depth   = 4,
  parameter int min_gap = 4
) (
  input  logic                         clk_s,
  input  logic                         rst_s_n,
  input  logic                         init_s_n,
  data_sync_na_src_pacer_if.slave      bus,
  output logic [$clog2(depth+1)-1:0]   fifo_count,
  output logic                         busy
);

  localparam int CW = $clog2(depth + 1);
  localparam int AW = $clog2(depth);
  localparam logic [CW-1:0] DEPTH_C  = CW'(depth);
  localparam logic [7:0]    GAP_INIT = 8'(min_gap - 2);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       gap_cnt, gap_cnt_nxt;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [width-1:0] mem [depth];
  logic             push, pop;

  // Ready is decoded from the registered count only, so a full FIFO never
  // accepts a word even when a pop happens on the same edge.
  assign bus.in_ready = (fifo_count < DEPTH_C);
  assign push         = bus.in_valid & bus.in_ready;
  assign bus.send_s   = (state == SEND);
  assign busy         = (state != IDLE) || (fifo_count != '0);

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop       = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        state_nxt   = GAP;
        gap_cnt_nxt = GAP_INIT;
      end
      GAP: begin
        if (gap_cnt != '0) begin
          gap_cnt_nxt = gap_cnt - 8'd1;
        end else if (fifo_count != '0) begin
          pop       = 1'b1;
          state_nxt = SEND;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_s or negedge rst_s_n) begin
    if (!rst_s_n) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      bus.data_s <= '0;
    end else if (!init_s_n) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      bus.data_s <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + AW'(1);
        bus.data_s <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count define which entries are
  // valid, so stale contents are never observed.
  always_ff @(posedge clk_s) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

endmodule
